// File: rtl/window_3x3_pkg.sv
// Shared definitions for the 3x3 window generator.
//
// WORD_SIZE normally comes from the project-wide global.vh. The guarded
// default below keeps this slice self-contained when that header is not
// part of the compile.
//
// Contents:
//   WORD_W    pixel width in bits
//   WIN_TAPS  number of window taps (p1..p9)
//   FILL      first row/column index at which a full window is available
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package window_3x3_pkg;

    localparam int WORD_W   = `WORD_SIZE;
    localparam int WIN_TAPS = 9;
    localparam int FILL     = 2;

endpackage

// File: rtl/window_3x3_line.sv
// One image row of storage, addressed by column.
//
// Ports:
//   clk   clock; the write happens on posedge
//   we    write enable
//   addr  column address
//   din   pixel to store at addr
//   dout  pixel currently stored at addr (combinational read)
//
// The read is asynchronous, so dout shows the old contents of addr during
// the same cycle that a write to addr is pending (read-before-write).
module line_buffer
    import window_3x3_pkg::*;
#(
    parameter int DEPTH     = 640,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    din,
    output logic [WORD_W-1:0]    dout
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    assign dout = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
    end

endmodule

// File: rtl/window_3x3.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel window stage.
//
// Ports:
//   clk        single clock, all state on posedge
//   reset      synchronous, active-high
//   in_valid   in_data carries a raster-order pixel this cycle
//   in_sof     with in_valid: this pixel is (0,0) of a new frame
//   in_data    pixel value
//   out_valid  p1..p9 hold a complete interior window
//   out_eof    with out_valid: last window of the frame
//   p1..p9     window pixels, row-major (p1 top-left, p9 bottom-right)
//
// Two line buffers hold the previous two rows. Each accepted pixel shifts
// the three window rows left by one, taking the new right-hand column from
// lb1 (two rows up), lb0 (one row up) and the incoming pixel. A window is
// flagged one cycle after a pixel at row>=2, col>=2, so the first two
// columns of a row and the first two rows of a frame only prime the
// registers. Line buffer contents are never cleared; that gating is what
// keeps stale data out of emitted windows.
module window_3x3
    import window_3x3_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_BITS   = 10,
    parameter int ROW_BITS   = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_eof,
    output logic [WORD_W-1:0] p1,
    output logic [WORD_W-1:0] p2,
    output logic [WORD_W-1:0] p3,
    output logic [WORD_W-1:0] p4,
    output logic [WORD_W-1:0] p5,
    output logic [WORD_W-1:0] p6,
    output logic [WORD_W-1:0] p7,
    output logic [WORD_W-1:0] p8,
    output logic [WORD_W-1:0] p9
);

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_HEIGHT - 1);

    logic [COL_BITS-1:0] col_q, col_d, pix_col;
    logic [ROW_BITS-1:0] row_q, row_d, pix_row;
    logic                out_valid_q, out_valid_d;
    logic                out_eof_q, out_eof_d;
    logic [WORD_W-1:0]   win_q [WIN_TAPS];
    logic [WORD_W-1:0]   lb0_rd, lb1_rd;
    logic                lb_we;

    // A pixel arriving together with reset is dropped entirely.
    assign lb_we = in_valid && !reset;

    // in_sof overrides the counters for the position of this very pixel.
    always_comb begin
        pix_col     = in_sof ? '0 : col_q;
        pix_row     = in_sof ? '0 : row_q;
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = 1'b0;
        out_eof_d   = 1'b0;
        if (in_valid) begin
            if (pix_col == LAST_COL) begin
                col_d = '0;
                row_d = (pix_row == LAST_ROW) ? '0 : pix_row + ROW_BITS'(1);
            end else begin
                col_d = pix_col + COL_BITS'(1);
                row_d = pix_row;
            end
            out_valid_d = (pix_row >= ROW_BITS'(FILL)) && (pix_col >= COL_BITS'(FILL));
            out_eof_d   = (pix_row == LAST_ROW) && (pix_col == LAST_COL);
        end
    end

    line_buffer #(
        .DEPTH     (IMG_WIDTH),
        .ADDR_BITS (COL_BITS)
    ) u_lb0 (
        .clk  (clk),
        .we   (lb_we),
        .addr (pix_col),
        .din  (in_data),
        .dout (lb0_rd)
    );

    // lb1 is fed from lb0's pre-write value, so it always lags lb0 by a row.
    line_buffer #(
        .DEPTH     (IMG_WIDTH),
        .ADDR_BITS (COL_BITS)
    ) u_lb1 (
        .clk  (clk),
        .we   (lb_we),
        .addr (pix_col),
        .din  (lb0_rd),
        .dout (lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int i = 0; i < WIN_TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_eof_q   <= out_eof_d;
            if (in_valid) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= lb1_rd;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= lb0_rd;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= in_data;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_eof   = out_eof_q;
    assign p1 = win_q[0];
    assign p2 = win_q[1];
    assign p3 = win_q[2];
    assign p4 = win_q[3];
    assign p5 = win_q[4];
    assign p6 = win_q[5];
    assign p7 = win_q[6];
    assign p8 = win_q[7];
    assign p9 = win_q[8];

endmodule
